// File: rtl/fifo_rd_arb.sv
// Round-robin read-port arbiter for an async FIFO: grants one consumer at a time,
// pops its requested burst and delivers each word through one registered valid/ready stage.
module fifo_rd_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 2,
  parameter int BL_W       = 3
) (
  input  logic                       rclk,
  input  logic                       rst_n,
  input  logic                       fifo_empty,
  input  logic [DATA_WIDTH-1:0]      fifo_rdata,
  output logic                       fifo_rinc,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*BL_W-1:0]    burst_len,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       out_valid,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [$clog2(NUM_REQ)-1:0] out_id,
  output logic                       out_last,
  input  logic                       out_ready
);

  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic [ID_W-1:0]       prio_ptr_q, prio_ptr_d;
  logic [BL_W-1:0]       remaining_q, remaining_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ID_W-1:0]       out_id_q, out_id_d;
  logic                  out_last_q, out_last_d;

  logic                  found_hi;
  logic [ID_W-1:0]       sel_hi, sel_lo, sel_id;
  logic [BL_W-1:0]       sel_len;
  logic                  pop;
  logic                  handshake;

  // Round-robin pick: lowest requester at or above prio_ptr, else wrap to the lowest overall.
  always_comb begin
    found_hi = 1'b0;
    sel_hi   = '0;
    sel_lo   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel_lo = ID_W'(i);
        if (ID_W'(i) >= prio_ptr_q) begin
          sel_hi   = ID_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    sel_id = found_hi ? sel_hi : sel_lo;

    sel_len = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == sel_id) sel_len = burst_len[i*BL_W +: BL_W];
    end
  end

  assign handshake = out_valid_q && out_ready;

  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    grant_d     = grant_q;
    id_d        = id_q;
    prio_ptr_d  = prio_ptr_q;
    remaining_d = remaining_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
    pop         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          id_d        = sel_id;
          remaining_d = (sel_len == '0) ? BL_W'(1) : sel_len;
          for (int i = 0; i < NUM_REQ; i++) grant_d[i] = (ID_W'(i) == sel_id);
          state_d     = S_BURST;
        end
      end

      S_BURST: begin
        // The output stage may refill in the same cycle it hands a word off.
        pop = !fifo_empty && (!out_valid_q || out_ready) && (remaining_q != '0);
        if (pop) begin
          out_valid_d = 1'b1;
          out_data_d  = fifo_rdata;
          out_id_d    = id_q;
          out_last_d  = (remaining_q == BL_W'(1));
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == BL_W'(1)) state_d = S_DRAIN;
        end else if (handshake) begin
          out_valid_d = 1'b0;
        end
      end

      S_DRAIN: begin
        if (handshake) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          grant_d     = '0;
          prio_ptr_d  = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the data register is reset too, so the output word reads 0 out of reset.
  always_ff @(posedge rclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      id_q        <= '0;
      prio_ptr_q  <= '0;
      remaining_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      state_q     <= state_d;
      grant_q     <= grant_d;
      id_q        <= id_d;
      prio_ptr_q  <= prio_ptr_d;
      remaining_q <= remaining_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
    end
  end

  assign fifo_rinc = pop;
  assign grant     = grant_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_fifo_rd_arb.sv
// Directed bench for fifo_rd_arb: a registered-flag FIFO model feeds the DUT and a
// negedge monitor logs handshakes and grants for hand-computed expectations.
module tb_fifo_rd_arb;

  localparam int DW  = 8;
  localparam int NR  = 2;
  localparam int BLW = 3;
  localparam int IDW = 1;

  logic              rclk = 1'b0;
  logic              rst_n;
  logic              fifo_empty = 1'b1;
  logic [DW-1:0]     fifo_rdata = '0;
  logic              fifo_rinc;
  logic [NR-1:0]     req;
  logic [NR*BLW-1:0] burst_len;
  logic [NR-1:0]     grant;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [IDW-1:0]    out_id;
  logic              out_last;
  logic              out_ready;

  fifo_rd_arb #(.DATA_WIDTH(DW), .NUM_REQ(NR), .BL_W(BLW)) dut (
    .rclk      (rclk),
    .rst_n     (rst_n),
    .fifo_empty(fifo_empty),
    .fifo_rdata(fifo_rdata),
    .fifo_rinc (fifo_rinc),
    .req       (req),
    .burst_len (burst_len),
    .grant     (grant),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last),
    .out_ready (out_ready)
  );

  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model: flags are registered, so a pop or push shows on the next edge.
  logic [DW-1:0] fifo_q[$];
  logic          pop_pend = 1'b0;
  int            cyc = 0;

  always @(posedge rclk) cyc <= cyc + 1;

  always @(negedge rclk) begin
    pop_pend = fifo_rinc;
    if (fifo_rinc) check("rinc_while_empty", 32'(fifo_empty), 0);
  end

  always @(posedge rclk) begin
    if (pop_pend && fifo_q.size() > 0) void'(fifo_q.pop_front());
    fifo_empty <= (fifo_q.size() == 0);
    fifo_rdata <= (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  typedef struct {
    logic [IDW-1:0] id;
    logic           last;
    logic [DW-1:0]  data;
    int             cyc;
  } beat_t;

  beat_t         rx[$];
  logic [NR-1:0] glog[$];
  logic [NR-1:0] grant_prev = '0;

  always @(negedge rclk) begin
    if (rst_n && out_valid && out_ready) rx.push_back('{out_id, out_last, out_data, cyc});
    if (rst_n && grant != '0 && grant != grant_prev) glog.push_back(grant);
    grant_prev = grant;
  end

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] first, input int n);
    fifo_q.delete();
    for (int i = 0; i < n; i++) fifo_q.push_back(first + DW'(i));
    rx.delete();
    glog.delete();
    step();
  endtask

  task automatic start(input logic [NR-1:0] r, input logic [NR*BLW-1:0] bl);
    burst_len = bl;
    req       = r;
    step();
  endtask

  task automatic wait_idle(input string tag, output int drop_cyc);
    int n = 0;
    while (grant != '0 && n < 40) begin
      step();
      n++;
    end
    drop_cyc = cyc;
    check(tag, 32'(grant), 0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  int drop;

  initial begin
    rst_n     = 1'b0;
    req       = 2'b11;
    burst_len = {3'd1, 3'd1};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'h10 + 8'(i));

    // Reset holds everything quiet even with both requests up.
    repeat (3) step();
    check("rst_grant", 32'(grant), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_rinc", 32'(fifo_rinc), 0);
    check("rst_data", 32'(out_data), 0);
    rst_n = 1'b1;
    step();
    check("rst_first_grant", 32'(grant), 32'h1);
    req = '0;
    check("rst_first_pop", 32'(fifo_rinc), 1);
    wait_idle("rst_idle", drop);
    check("rst_rx_n", 32'(rx.size()), 1);
    if (rx.size() == 1) check("rst_rx_data", 32'(rx[0].data), 32'h10);

    // Single burst of 4 to requester 0.
    load(8'hA1, 4);
    start(2'b01, {3'd0, 3'd4});
    req = '0;
    check("single_grant", 32'(grant), 32'h1);
    wait_idle("single_idle", drop);
    check("single_n", 32'(rx.size()), 4);
    if (rx.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("single_data", 32'(rx[i].data), 32'hA1 + i);
        check("single_id", 32'(rx[i].id), 0);
        check("single_last", 32'(rx[i].last), (i == 3) ? 1 : 0);
        check("single_cyc", rx[i].cyc, rx[0].cyc + i);
      end
      check("single_drop", drop, rx[3].cyc + 1);
    end

    // Round-robin with both requesting, burst_len 2 each.
    reset_pulse();
    load(8'h30, 8);
    start(2'b11, {3'd2, 3'd2});
    begin
      int n = 0;
      while (rx.size() < 8 && n < 80) begin
        step();
        n++;
      end
    end
    req = '0;
    wait_idle("rr_idle", drop);
    check("rr_n", 32'(rx.size()), 8);
    if (rx.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check("rr_data", 32'(rx[i].data), 32'h30 + i);
        check("rr_id", 32'(rx[i].id), (i / 2) % 2);
        check("rr_last", 32'(rx[i].last), i % 2);
        if (i > 0) check("rr_gap", rx[i].cyc - rx[i-1].cyc, (i % 2 == 1) ? 1 : 3);
      end
    end
    check("rr_grants_n", 32'(glog.size()), 4);
    if (glog.size() == 4) begin
      check("rr_g0", 32'(glog[0]), 32'h1);
      check("rr_g1", 32'(glog[1]), 32'h2);
      check("rr_g2", 32'(glog[2]), 32'h1);
      check("rr_g3", 32'(glog[3]), 32'h2);
    end

    // Backpressure: consumer stalls for 3 cycles after the first word.
    load(8'h41, 3);
    start(2'b01, {3'd0, 3'd3});
    req = '0;
    check("bp_grant", 32'(grant), 32'h1);
    step();
    check("bp_first_valid", 32'(out_valid), 1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_hold_data", 32'(out_data), 32'h41);
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_no_rinc", 32'(fifo_rinc), 0);
      step();
    end
    out_ready = 1'b1;
    wait_idle("bp_idle", drop);
    check("bp_n", 32'(rx.size()), 3);
    if (rx.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("bp_data", 32'(rx[i].data), 32'h41 + i);
        check("bp_last", 32'(rx[i].last), (i == 2) ? 1 : 0);
      end
    end

    // FIFO runs dry mid-burst: grant holds and popping stops until refilled.
    load(8'h51, 2);
    start(2'b01, {3'd0, 3'd4});
    req = '0;
    check("empty_grant", 32'(grant), 32'h1);
    repeat (5) step();
    for (int i = 0; i < 3; i++) begin
      check("empty_hold_grant", 32'(grant), 32'h1);
      check("empty_no_rinc", 32'(fifo_rinc), 0);
      check("empty_no_valid", 32'(out_valid), 0);
      step();
    end
    check("empty_rx_part", 32'(rx.size()), 2);
    fifo_q.push_back(8'h53);
    fifo_q.push_back(8'h54);
    wait_idle("empty_idle", drop);
    check("empty_n", 32'(rx.size()), 4);
    if (rx.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("empty_data", 32'(rx[i].data), 32'h51 + i);
        check("empty_last", 32'(rx[i].last), (i == 3) ? 1 : 0);
      end
    end
    check("empty_end_valid", 32'(out_valid), 0);

    // burst_len 0 is a single-word burst.
    load(8'h61, 2);
    start(2'b01, {3'd0, 3'd0});
    req = '0;
    check("bl0_grant", 32'(grant), 32'h1);
    wait_idle("bl0_idle", drop);
    check("bl0_n", 32'(rx.size()), 1);
    if (rx.size() == 1) begin
      check("bl0_data", 32'(rx[0].data), 32'h61);
      check("bl0_last", 32'(rx[0].last), 1);
    end
    check("bl0_left", 32'(fifo_q.size()), 1);

    // Reset mid-burst on requester 1 after two words have been popped.
    load(8'h71, 4);
    start(2'b10, {3'd4, 3'd0});
    req = '0;
    check("mrst_grant", 32'(grant), 32'h2);
    step();
    step();
    check("mrst_pre_valid", 32'(out_valid), 1);
    check("mrst_pre_data", 32'(out_data), 32'h72);
    check("mrst_pre_id", 32'(out_id), 1);
    rst_n = 1'b0;
    #1;
    check("mrst_grant0", 32'(grant), 0);
    check("mrst_valid0", 32'(out_valid), 0);
    check("mrst_data0", 32'(out_data), 0);
    check("mrst_id0", 32'(out_id), 0);
    check("mrst_last0", 32'(out_last), 0);
    check("mrst_rinc0", 32'(fifo_rinc), 0);
    check("mrst_left", 32'(fifo_q.size()), 2);
    step();
    rst_n = 1'b1;
    repeat (2) step();
    check("mrst_after_grant", 32'(grant), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/fifo_rd_arb.md
# fifo_rd_arb

Read-side arbiter that shares one asynchronous FIFO read port among NUM_REQ consumers in the rclk domain. It grants the port to one requester at a time in round-robin order and pops a requested burst of words from the FIFO. Each word is delivered through a single registered valid/ready output stage, tagged with the requester ID and a last-word flag. It sits between the FIFO read-pointer/empty logic and the consumer blocks.

## Interface
Parameters:
- DATA_WIDTH, 8, FIFO word width
- NUM_REQ, 2, number of requesters, 2..4
- BL_W, 3, burst-length field width; burst_len value 0 is treated as 1

Ports:
- rclk  in  1  read-domain clock
- rst_n  in  1  reset, asynchronous, active-low
- fifo_empty  in  1  FIFO empty flag, registered and valid every cycle
- fifo_rdata  in  DATA_WIDTH  FIFO head word, valid whenever fifo_empty=0
- fifo_rinc  out  1  pop strobe to FIFO, combinational
- req  in  NUM_REQ  per-requester burst request, level
- burst_len  in  NUM_REQ*BL_W  per-requester burst length, slice i = requester i
- grant  out  NUM_REQ  one-hot, registered, high for the whole burst
- out_valid  out  1  output word valid
- out_data  out  DATA_WIDTH  output word
- out_id  out  clog2(NUM_REQ)  requester owning out_data
- out_last  out  1  final word of burst
- out_ready  in  1  consumer accepts word

## Operation
- States: IDLE, BURST, DRAIN.
- IDLE:
  - If req≠0, select the first set bit at or after prio_ptr, wrapping modulo NUM_REQ.
  - Latch the selected id and remaining = max(burst_len[id],1).
  - Set grant[id] and go to BURST.
  - req and burst_len are sampled only in IDLE. Later changes have no effect on the current burst.
- BURST:
  - pop = !fifo_empty && (!out_valid || out_ready) && remaining≠0.
  - fifo_rinc = pop, asserted only in BURST.
  - On pop:
    - out_valid←1, out_data←fifo_rdata, out_id←id.
    - out_last←(remaining==1).
    - remaining←remaining−1.
  - If there is an output handshake without a pop: out_valid←0.
  - After the pop with remaining==1, go to DRAIN.
- DRAIN:
  - No pops.
  - On out_valid && out_ready: out_valid←0, out_last←0, grant←0, prio_ptr←(id+1) mod NUM_REQ, go to IDLE.
- FIFO empty mid-burst:
  - The burst stalls. grant stays high and no timeout applies.
  - Popping resumes in the first cycle fifo_empty=0.
- Output register holds its contents stable while out_valid && !out_ready.
- remaining is BL_W bits wide and never underflows, because pop requires remaining≠0.
- Reset values: state IDLE, grant 0, out_valid 0, out_data 0, out_id 0, out_last 0, prio_ptr 0, remaining 0, fifo_rinc 0.
- Reset asserted mid-burst: all state clears immediately. Unpopped words of the burst remain in the FIFO.

## Timing
- req seen in IDLE at cycle N → grant at N+1.
- First pop is possible at N+1; its out_valid is at N+2.
- Sustained throughput is 1 word/cycle while out_ready=1 and fifo_empty=0. A pop and a handshake in the same cycle are allowed.
- The last handshake at cycle M clears grant at M+1, where the state is IDLE. The earliest next grant is M+2, so there is one idle cycle between bursts.
- fifo_empty is assumed accurate the cycle after each pop, so back-to-back pops never underflow.
- The block never asserts fifo_rinc while fifo_empty=1.

## Test plan
- Reset: hold rst_n=0 with req=2'b11 → grant=0, out_valid=0, fifo_rinc=0.
  - Release reset with FIFO holding 8 words → grant=2'b01 first, because prio_ptr=0.
- Single burst: req0, burst_len0=4, FIFO holds A,B,C,D, out_ready=1.
  - Expect out_data A,B,C,D on 4 consecutive cycles.
  - out_id=0; out_last only on D.
  - grant0 drops one cycle after D is accepted.
- Round-robin: req=2'b11 continuously, burst_len=2 each, FIFO holds 8 words.
  - Grant order is 0,1,0,1.
  - out_id toggles every 2 words, with one idle cycle between bursts.
- Backpressure: burst_len=3 with out_ready low for 3 cycles after the first word.
  - out_data holds the first word and fifo_rinc stays 0 during the stall.
  - All 3 words are delivered in order with no loss or duplication.
- Empty stall: burst_len=4 with only 2 words in the FIFO.
  - 2 words are delivered, then grant stays high and fifo_rinc stays 0.
  - Write 2 more words → the remaining 2 words are delivered, out_last is on the 4th, and the block returns to IDLE.
- burst_len=0 and mid-burst reset:
  - burst_len=0 → exactly 1 word is popped with out_last=1.
  - Assert rst_n low after 2 of 4 words → outputs return to reset values at once and fifo_rinc=0.
